// File: rtl/uart_rx_loader.sv
// UART 8N1 receiver that packs bytes into 32-bit words and writes them into RAM over Wishbone.
// Latency: byte strobe one cycle after the stop-bit sample; bus request one cycle after a word lands in holding.
// Backpressure: one-entry holding register; a completed word meeting a full holding register is dropped and sets o_overrun.
//
// Ports:
//   i_wb_clk, i_wb_rst        : clock, asynchronous active-high reset
//   i_rx                      : asynchronous serial input, idle high
//   i_cpu_cyc                 : CPU owns the RAM bus while high; no new cycle starts then
//   o_wb_adr/dat/sel/we/cyc   : Wishbone write master, i_wb_ack ends the cycle
//   o_byte, o_byte_valid      : last good byte and its one-cycle strobe
//   o_frame_err               : one-cycle strobe on a low stop bit
//   o_overrun, i_clr          : sticky lost-word flag and its synchronous clear
module uart_rx_loader #(
   parameter int          CLKS_PER_BIT = 104,
   parameter logic [31:0] ADR_LL       = 32'h00000C00,
   parameter logic [31:0] ADR_UL       = 32'h00C10000
) (
   input  logic        i_wb_clk,
   input  logic        i_wb_rst,
   input  logic        i_rx,
   input  logic        i_cpu_cyc,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic        i_wb_ack,
   output logic [7:0]  o_byte,
   output logic        o_byte_valid,
   output logic        o_frame_err,
   output logic        o_overrun,
   input  logic        i_clr
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic       {BUS_IDLE, BUS_REQ} bus_state_t;

   rx_state_t  rx_state, rx_next;
   bus_state_t bus_state, bus_next;

   // ---------------------------------------------------------------
   // Synchronizer; rx_prev is one more stage used only for the
   // falling-edge detect so the edge is seen on synchronized data.
   // ---------------------------------------------------------------
   logic rx_meta, rx_sync, rx_prev;

   always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // ---------------------------------------------------------------
   // Receiver FSM
   // ---------------------------------------------------------------
   logic [15:0] clk_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift_reg;
   logic        half_hit, full_hit;
   logic        cnt_clr, shift_en, byte_good, byte_bad;

   assign half_hit = (clk_cnt == 16'(HALF_BIT - 1));
   assign full_hit = (clk_cnt == 16'(CLKS_PER_BIT - 1));

   always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) rx_state <= RX_IDLE;
      else          rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
         // A start bit that is high again at its midpoint was a glitch.
         RX_START: if (half_hit) rx_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (full_hit && bit_cnt == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (full_hit) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      cnt_clr   = 1'b0;
      shift_en  = 1'b0;
      byte_good = 1'b0;
      byte_bad  = 1'b0;
      case (rx_state)
         RX_IDLE:  cnt_clr = 1'b1;
         RX_START: cnt_clr = half_hit;
         RX_DATA: begin
            cnt_clr  = full_hit;
            shift_en = full_hit;
         end
         RX_STOP: begin
            cnt_clr   = full_hit;
            byte_good = full_hit &  rx_sync;
            byte_bad  = full_hit & ~rx_sync;
         end
         default:  cnt_clr = 1'b1;
      endcase
   end

   always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) begin
         clk_cnt      <= '0;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         o_byte       <= '0;
         o_byte_valid <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         clk_cnt <= cnt_clr ? 16'd0 : clk_cnt + 16'd1;
         if (rx_state == RX_IDLE) bit_cnt <= '0;
         else if (shift_en)       bit_cnt <= bit_cnt + 3'd1;
         // LSB arrives first, so shift in from the top.
         if (shift_en) shift_reg <= {rx_sync, shift_reg[7:1]};
         if (byte_good) o_byte <= shift_reg;
         o_byte_valid <= byte_good;
         o_frame_err  <= byte_bad;
      end
   end

   // ---------------------------------------------------------------
   // Word assembly and holding register
   // ---------------------------------------------------------------
   logic [1:0]  byte_idx;
   logic [23:0] asm_word;
   logic [31:0] hold_dat;
   logic        hold_full;
   logic        hold_take, hold_load, overrun_set;
   logic [31:0] wr_ptr, ptr_inc;

   assign hold_take   = (bus_state == BUS_REQ) && i_wb_ack;
   // A word may enter holding on the same edge the bus drains it.
   assign hold_load   = byte_good && (byte_idx == 2'd3) && (!hold_full || hold_take);
   assign overrun_set = byte_good && (byte_idx == 2'd3) && hold_full && !hold_take;
   assign ptr_inc     = wr_ptr + 32'd4;

   always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) begin
         byte_idx  <= '0;
         asm_word  <= '0;
         hold_dat  <= '0;
         hold_full <= 1'b0;
         o_overrun <= 1'b0;
         wr_ptr    <= ADR_LL;
      end else begin
         if (byte_good) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
               2'd0:    asm_word[7:0]   <= shift_reg;
               2'd1:    asm_word[15:8]  <= shift_reg;
               2'd2:    asm_word[23:16] <= shift_reg;
               default: ;
            endcase
         end
         if (hold_load) hold_dat <= {shift_reg, asm_word};
         if (hold_load)      hold_full <= 1'b1;
         else if (hold_take) hold_full <= 1'b0;
         if (overrun_set) o_overrun <= 1'b1;
         else if (i_clr)  o_overrun <= 1'b0;
         // ADR_UL itself is a valid target; wrap only once past it.
         if (hold_take) wr_ptr <= (ptr_inc > ADR_UL) ? ADR_LL : ptr_inc;
      end
   end

   // ---------------------------------------------------------------
   // Bus FSM
   // ---------------------------------------------------------------
   always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) bus_state <= BUS_IDLE;
      else          bus_state <= bus_next;
   end

   always_comb begin
      bus_next = bus_state;
      case (bus_state)
         BUS_IDLE: if (hold_full && !i_cpu_cyc) bus_next = BUS_REQ;
         // Once started the cycle runs to ack regardless of i_cpu_cyc.
         BUS_REQ:  if (i_wb_ack) bus_next = BUS_IDLE;
         default:  bus_next = BUS_IDLE;
      endcase
   end

   // Address and data come straight from the pointer and holding
   // register, neither of which changes while a cycle is open.
   always_comb begin
      o_wb_cyc = (bus_state == BUS_REQ);
      o_wb_we  = (bus_state == BUS_REQ);
      o_wb_sel = 4'b1111;
      o_wb_adr = wr_ptr;
      o_wb_dat = hold_dat;
   end

endmodule

// File: tb/tb_uart_rx_loader.sv
module tb_uart_rx_loader;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx = 1'b1;
   logic        cpu_cyc = 1'b0;
   logic        ack = 1'b0;
   logic        clr = 1'b0;
   logic        auto_ack = 1'b1;
   logic [31:0] wb_adr, wb_dat;
   logic [3:0]  wb_sel;
   logic        wb_we, wb_cyc;
   logic [7:0]  rx_byte;
   logic        byte_valid, frame_err, overrun;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int vld_cnt = 0;
   int err_cnt = 0;
   int cyc_cnt = 0;
   logic [31:0] wr_adr[$];
   logic [31:0] wr_dat[$];

   uart_rx_loader #(
      .CLKS_PER_BIT(CPB),
      .ADR_LL(32'h00000C00),
      .ADR_UL(32'h00000C08)
   ) dut (
      .i_wb_clk(clk),
      .i_wb_rst(rst),
      .i_rx(rx),
      .i_cpu_cyc(cpu_cyc),
      .o_wb_adr(wb_adr),
      .o_wb_dat(wb_dat),
      .o_wb_sel(wb_sel),
      .o_wb_we(wb_we),
      .o_wb_cyc(wb_cyc),
      .i_wb_ack(ack),
      .o_byte(rx_byte),
      .o_byte_valid(byte_valid),
      .o_frame_err(frame_err),
      .o_overrun(overrun),
      .i_clr(clr)
   );

   always #5 clk = ~clk;

   // Bus slave and strobe monitor, sampled on the falling edge. Ack is
   // raised one cycle after cyc is first seen, so it lasts exactly one cycle.
   always @(negedge clk) begin
      if (byte_valid) vld_cnt = vld_cnt + 1;
      if (frame_err)  err_cnt = err_cnt + 1;
      if (wb_cyc)     cyc_cnt = cyc_cnt + 1;
      if (wb_cyc && !ack && auto_ack) begin
         wr_adr.push_back(wb_adr);
         wr_dat.push_back(wb_dat);
      end
      ack = auto_ack && wb_cyc && !ack;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop;
      tick(CPB);
      rx = 1'b1;
      tick(CPB);
   endtask

   task automatic wait_writes(input int n, input string name);
      int t;
      t = 0;
      while (wr_adr.size() < n && t < 2000) begin
         tick(1);
         t++;
      end
      chk_cnt++;
      if (wr_adr.size() < n) $display("FAIL %s_timeout: writes %0d want %0d", name, wr_adr.size(), n);
      else pass_cnt++;
   endtask

   task automatic test_reset;
      #1;
      chk_cnt++; if (wb_cyc !== 1'b0) $display("FAIL rst_cyc: got %b want 0", wb_cyc); else pass_cnt++;
      chk_cnt++; if (wb_we !== 1'b0) $display("FAIL rst_we: got %b want 0", wb_we); else pass_cnt++;
      chk_cnt++; if (wb_sel !== 4'hF) $display("FAIL rst_sel: got %h want f", wb_sel); else pass_cnt++;
      chk_cnt++; if (wb_adr !== 32'h00000C00) $display("FAIL rst_adr: got %h want 00000c00", wb_adr); else pass_cnt++;
      chk_cnt++; if (wb_dat !== 32'h0) $display("FAIL rst_dat: got %h want 0", wb_dat); else pass_cnt++;
      chk_cnt++; if (rx_byte !== 8'h00) $display("FAIL rst_byte: got %h want 00", rx_byte); else pass_cnt++;
      chk_cnt++; if ({byte_valid, frame_err, overrun} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {byte_valid, frame_err, overrun}); else pass_cnt++;
      rst = 1'b0;
      tick(4);
   endtask

   task automatic test_single_word;
      int n0, v0;
      n0 = wr_adr.size();
      v0 = vld_cnt;
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      wait_writes(n0 + 1, "single");
      if (wr_adr.size() > n0) begin
         chk_cnt++; if (wr_adr[n0] !== 32'h00000C00) $display("FAIL single_adr: got %h want 00000c00", wr_adr[n0]); else pass_cnt++;
         chk_cnt++; if (wr_dat[n0] !== 32'h44332211) $display("FAIL single_dat: got %h want 44332211", wr_dat[n0]); else pass_cnt++;
      end
      tick(5);
      chk_cnt++; if (wb_adr !== 32'h00000C04) $display("FAIL single_next_ptr: got %h want 00000c04", wb_adr); else pass_cnt++;
      chk_cnt++; if (wb_cyc !== 1'b0) $display("FAIL single_cyc_drop: got %b want 0", wb_cyc); else pass_cnt++;
      chk_cnt++; if (vld_cnt - v0 != 4) $display("FAIL single_strobes: got %0d want 4", vld_cnt - v0); else pass_cnt++;
      chk_cnt++; if (rx_byte !== 8'h44) $display("FAIL single_last_byte: got %h want 44", rx_byte); else pass_cnt++;
   endtask

   task automatic test_overrun;
      int n0, c0;
      n0 = wr_adr.size();
      c0 = cyc_cnt;
      cpu_cyc = 1'b1;
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
      chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_flag_set: got %b want 1", overrun); else pass_cnt++;
      chk_cnt++; if (cyc_cnt != c0) $display("FAIL ovr_no_cyc: got %0d cyc cycles want 0", cyc_cnt - c0); else pass_cnt++;
      cpu_cyc = 1'b0;
      wait_writes(n0 + 1, "ovr");
      if (wr_adr.size() > n0) begin
         chk_cnt++; if (wr_adr[n0] !== 32'h00000C04) $display("FAIL ovr_adr: got %h want 00000c04", wr_adr[n0]); else pass_cnt++;
         chk_cnt++; if (wr_dat[n0] !== 32'h04030201) $display("FAIL ovr_dat: got %h want 04030201", wr_dat[n0]); else pass_cnt++;
      end
      tick(40);
      chk_cnt++; if (wr_adr.size() != n0 + 1) $display("FAIL ovr_one_write: got %0d writes want 1", wr_adr.size() - n0); else pass_cnt++;
      chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else pass_cnt++;
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun); else pass_cnt++;
   endtask

   task automatic test_frame_err;
      int n0, v0, e0;
      n0 = wr_adr.size();
      v0 = vld_cnt;
      e0 = err_cnt;
      send_byte(8'h10, 1'b1);
      send_byte(8'hA5, 1'b0);
      chk_cnt++; if (err_cnt - e0 != 1) $display("FAIL ferr_strobe: got %0d want 1", err_cnt - e0); else pass_cnt++;
      chk_cnt++; if (vld_cnt - v0 != 1) $display("FAIL ferr_no_valid: got %0d want 1", vld_cnt - v0); else pass_cnt++;
      chk_cnt++; if (rx_byte !== 8'h10) $display("FAIL ferr_byte_kept: got %h want 10", rx_byte); else pass_cnt++;
      send_byte(8'h20, 1'b1);
      send_byte(8'h30, 1'b1);
      send_byte(8'h40, 1'b1);
      wait_writes(n0 + 1, "ferr");
      if (wr_adr.size() > n0) begin
         // Pointer reaches the upper limit, which is itself written.
         chk_cnt++; if (wr_adr[n0] !== 32'h00000C08) $display("FAIL ferr_adr_ul: got %h want 00000c08", wr_adr[n0]); else pass_cnt++;
         chk_cnt++; if (wr_dat[n0] !== 32'h40302010) $display("FAIL ferr_dat: got %h want 40302010", wr_dat[n0]); else pass_cnt++;
      end
      tick(5);
      chk_cnt++; if (wb_adr !== 32'h00000C00) $display("FAIL wrap_ptr: got %h want 00000c00", wb_adr); else pass_cnt++;
   endtask

   task automatic test_glitch;
      int n0, v0, e0;
      n0 = wr_adr.size();
      v0 = vld_cnt;
      e0 = err_cnt;
      rx = 1'b0;
      tick(CPB / 4);
      rx = 1'b1;
      tick(3 * CPB);
      chk_cnt++; if (vld_cnt != v0 || err_cnt != e0) $display("FAIL glitch_strobes: got valid %0d err %0d want 0 0", vld_cnt - v0, err_cnt - e0); else pass_cnt++;
      chk_cnt++; if (wr_adr.size() != n0) $display("FAIL glitch_writes: got %0d want 0", wr_adr.size() - n0); else pass_cnt++;
   endtask

   task automatic test_addr_wrap;
      int n0;
      n0 = wr_adr.size();
      send_byte(8'h5A, 1'b1);
      send_byte(8'h6B, 1'b1);
      send_byte(8'h7C, 1'b1);
      send_byte(8'h8D, 1'b1);
      wait_writes(n0 + 1, "wrap");
      if (wr_adr.size() > n0) begin
         chk_cnt++; if (wr_adr[n0] !== 32'h00000C00) $display("FAIL wrap_adr: got %h want 00000c00", wr_adr[n0]); else pass_cnt++;
         chk_cnt++; if (wr_dat[n0] !== 32'h8D7C6B5A) $display("FAIL wrap_dat: got %h want 8d7c6b5a", wr_dat[n0]); else pass_cnt++;
      end
      tick(5);
      chk_cnt++; if (wb_adr !== 32'h00000C04) $display("FAIL wrap_next: got %h want 00000c04", wb_adr); else pass_cnt++;
   endtask

   task automatic test_reset_midframe;
      logic [7:0] b;
      b = 8'h3C;
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = b[4];
      tick(CPB / 2);
      rst = 1'b1;
      rx = 1'b1;
      #1;
      chk_cnt++; if (rx_byte !== 8'h00) $display("FAIL rstf_byte: got %h want 00", rx_byte); else pass_cnt++;
      chk_cnt++; if (wb_adr !== 32'h00000C00) $display("FAIL rstf_adr: got %h want 00000c00", wb_adr); else pass_cnt++;
      chk_cnt++; if ({wb_cyc, byte_valid, frame_err} !== 3'b000) $display("FAIL rstf_flags: got %b want 000", {wb_cyc, byte_valid, frame_err}); else pass_cnt++;
      tick(3);
      rst = 1'b0;
      tick(4);
   endtask

   task automatic test_reset_midcycle;
      int t, n0;
      auto_ack = 1'b0;
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h04, 1'b1);
      t = 0;
      while (!wb_cyc && t < 200) begin
         tick(1);
         t++;
      end
      chk_cnt++; if (wb_cyc !== 1'b1) $display("FAIL rstc_cyc_pending: got %b want 1", wb_cyc); else pass_cnt++;
      chk_cnt++; if (wb_dat !== 32'h04030201) $display("FAIL rstc_dat_pending: got %h want 04030201", wb_dat); else pass_cnt++;
      rst = 1'b1;
      #1;
      chk_cnt++; if ({wb_cyc, wb_we} !== 2'b00) $display("FAIL rstc_cyc: got %b want 00", {wb_cyc, wb_we}); else pass_cnt++;
      chk_cnt++; if (wb_dat !== 32'h0) $display("FAIL rstc_dat: got %h want 0", wb_dat); else pass_cnt++;
      tick(3);
      rst = 1'b0;
      tick(2);
      auto_ack = 1'b1;
      n0 = wr_adr.size();
      send_byte(8'hC3, 1'b1);
      send_byte(8'hD4, 1'b1);
      send_byte(8'hE5, 1'b1);
      send_byte(8'hF6, 1'b1);
      wait_writes(n0 + 1, "rstc");
      if (wr_adr.size() > n0) begin
         chk_cnt++; if (wr_adr[n0] !== 32'h00000C00) $display("FAIL rstc_after_adr: got %h want 00000c00", wr_adr[n0]); else pass_cnt++;
         chk_cnt++; if (wr_dat[n0] !== 32'hF6E5D4C3) $display("FAIL rstc_after_dat: got %h want f6e5d4c3", wr_dat[n0]); else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back;
      int n0;
      n0 = wr_adr.size();
      for (int i = 0; i < 8; i++) send_byte(8'h81 + 8'(i), 1'b1);
      wait_writes(n0 + 2, "b2b");
      if (wr_adr.size() > n0 + 1) begin
         chk_cnt++; if (wr_adr[n0] !== 32'h00000C04) $display("FAIL b2b_adr0: got %h want 00000c04", wr_adr[n0]); else pass_cnt++;
         chk_cnt++; if (wr_dat[n0] !== 32'h84838281) $display("FAIL b2b_dat0: got %h want 84838281", wr_dat[n0]); else pass_cnt++;
         chk_cnt++; if (wr_adr[n0+1] !== 32'h00000C08) $display("FAIL b2b_adr1: got %h want 00000c08", wr_adr[n0+1]); else pass_cnt++;
         chk_cnt++; if (wr_dat[n0+1] !== 32'h88878685) $display("FAIL b2b_dat1: got %h want 88878685", wr_dat[n0+1]); else pass_cnt++;
      end
      tick(5);
      chk_cnt++; if (wb_adr !== 32'h00000C00) $display("FAIL b2b_wrap: got %h want 00000c00", wb_adr); else pass_cnt++;
      chk_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun); else pass_cnt++;
   endtask

   initial begin
      tick(3);
      test_reset;
      test_single_word;
      test_overrun;
      test_frame_err;
      test_glitch;
      test_addr_wrap;
      test_reset_midframe;
      test_reset_midcycle;
      test_back_to_back;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/uart_rx_loader.md
UART_RX_LOADER -- requirements
Module: uart_rx_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, i_wb_clk cycles per UART bit (minimum 8).
REQ-002 SHALL have parameter ADR_LL, default 32'h00000C00, first RAM byte address written (word aligned).
REQ-003 SHALL have parameter ADR_UL, default 32'h00C10000, upper address limit (word aligned, greater than ADR_LL).
REQ-004 SHALL have port i_wb_clk  in  1  sole clock.
REQ-005 SHALL have port i_wb_rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_rx  in  1  UART serial input, 8N1, idle high, asynchronous to i_wb_clk.
REQ-007 SHALL have port i_cpu_cyc  in  1  CPU Wishbone cyc; high means the RAM bus is owned by the CPU.
REQ-008 SHALL have port o_wb_adr  out  32  RAM write byte address.
REQ-009 SHALL have port o_wb_dat  out  32  RAM write data.
REQ-010 SHALL have port o_wb_sel  out  4  byte enables, always 4'b1111 during a cycle.
REQ-011 SHALL have port o_wb_we  out  1  write enable, equal to o_wb_cyc.
REQ-012 SHALL have port o_wb_cyc  out  1  bus request/cycle active.
REQ-013 SHALL have port i_wb_ack  in  1  RAM acknowledge.
REQ-014 SHALL have port o_byte  out  8  last received byte.
REQ-015 SHALL have port o_byte_valid  out  1  one-cycle strobe per good byte.
REQ-016 SHALL have port o_frame_err  out  1  one-cycle strobe on bad stop bit.
REQ-017 SHALL have port o_overrun  out  1  sticky lost-word flag.
REQ-018 SHALL have port i_clr  in  1  synchronous clear of o_overrun.

Function
REQ-019 SHALL pass i_rx through a two-flop synchronizer, both flops reset to 1; all receiver decisions use the second flop.
REQ-020 Receiver SHALL be an FSM IDLE, START, DATA, STOP.
REQ-021 IDLE -> START on synchronized falling edge (1 then 0); bit counter and clock counter cleared.
REQ-022 START: at CLKS_PER_BIT/2 cycles, sample; if 0 -> DATA, if 1 (glitch) -> IDLE with no strobe.
REQ-023 DATA: sample every CLKS_PER_BIT cycles after start midpoint, LSB first, 8 bits, then -> STOP.
REQ-024 STOP: sample after CLKS_PER_BIT cycles; 1 -> o_byte updated and o_byte_valid high one cycle; 0 -> o_frame_err high one cycle, byte discarded; both -> IDLE.
REQ-025 Good bytes SHALL be packed little-endian into a 32-bit assembly register: byte n of word to bits [8n+7:8n], n = 0..3.
REQ-026 On the fourth byte, assembled word SHALL transfer to a one-entry holding register and the byte index SHALL wrap to 0, if the holding register is empty.
REQ-027 If the holding register is full when a fourth byte completes, the word SHALL be dropped, o_overrun set, byte index wrap to 0.
REQ-028 Bus FSM SHALL be IDLE, REQ: in IDLE with holding full and i_cpu_cyc low, assert o_wb_cyc/o_wb_we next cycle with o_wb_adr = write pointer, o_wb_dat = holding register.
REQ-029 o_wb_cyc SHALL remain high with stable adr/dat until i_wb_ack; on ack cyc drops same edge, holding register empties, pointer advances by 4.
REQ-030 After pointer advance, if pointer > ADR_UL it SHALL wrap to ADR_LL (ADR_UL itself is written).
REQ-031 A cycle SHALL not start while i_cpu_cyc is high; once started it is not aborted by i_cpu_cyc.
REQ-032 Word transfer into holding register and holding-register emptying on the same edge SHALL both take effect (no overrun).
REQ-033 i_clr and overrun set on the same edge: set wins.
REQ-034 Partial words (fewer than 4 bytes) SHALL remain pending indefinitely; no timeout flush.

Reset
REQ-035 During i_wb_rst: FSMs IDLE, pointer = ADR_LL, byte index 0, holding empty, o_wb_cyc/o_wb_we 0, o_wb_sel 4'b1111, o_wb_adr ADR_LL, o_wb_dat 0, o_byte 0, strobes 0, o_overrun 0.
REQ-036 Reset mid-frame or mid-bus-cycle SHALL abort immediately; in-flight byte/word lost; no further ack honoured.

Verification
REQ-037 Send 0x11,0x22,0x33,0x44, CPU idle, ack 1 cycle after cyc -> one write adr 0x00000C00 dat 0x44332211, next pointer 0x00000C04.
REQ-038 Send 8 bytes with i_cpu_cyc held high through both words -> second word overruns, o_overrun=1, no cyc until cpu_cyc low, then write of first word only.
REQ-039 Byte 0xA5 with stop bit 0 -> o_frame_err one cycle, no o_byte_valid, byte index unchanged.
REQ-040 Low pulse of CLKS_PER_BIT/4 on i_rx -> no strobes, FSM back in IDLE.
REQ-041 Preload pointer near limit (stream to ADR_UL) -> word written at 0x00C10000, next at 0x00000C00.
REQ-042 Assert i_wb_rst during DATA bit 4 and during pending cyc -> all outputs at reset values same cycle; next full frame received correctly.
